// File: rtl/dma_controller.sv
// Single-channel byte-copy DMA engine on the io register bus.
// The master port cycle-steals the memory bus whenever the CPU leaves it idle.
module dma_controller #(
    parameter logic [7:0] DMA_ADDRESS = 8'h90
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic [7:0]  address,
    input  logic        w_en,
    input  logic        r_en,
    output logic [7:0]  dout,
    input  logic        cpu_bus_active,
    output logic [15:0] dma_address,
    output logic [7:0]  dma_wdata,
    output logic        dma_w_en,
    output logic        dma_r_en,
    input  logic [7:0]  dma_rdata,
    output logic        busy,
    output logic        done_flag,
    input  logic        done_flag_clr
);

    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

    state_t      state;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic [15:0] len_next;
    logic        inc_src;
    logic        inc_dst;
    logic [7:0]  buffer;
    logic [7:0]  offset;
    logic        ctrl_wr;
    logic        abort;
    logic        start;
    logic        bus_free;
    logic        rd_fire;
    logic        wr_fire;
    logic        done_set;

    assign offset   = address - DMA_ADDRESS;
    assign ctrl_wr  = w_en && (offset == 8'd6);
    assign abort    = ctrl_wr && din[3];
    assign start    = ctrl_wr && din[0] && !din[3];
    assign len_next = len - 16'd1;

    // Master strobes are single-cycle and purely combinational so they can be
    // withdrawn in the very cycle the CPU claims the bus; an abort write also
    // suppresses the strobe of the cycle it lands in.
    assign bus_free = !cpu_bus_active && !abort;
    assign rd_fire  = (state == RD) && bus_free;
    assign wr_fire  = (state == WR) && bus_free;

    assign dma_r_en    = rd_fire;
    assign dma_w_en    = wr_fire;
    assign dma_address = rd_fire ? src : (wr_fire ? dst : 16'h0000);
    assign dma_wdata   = wr_fire ? buffer : 8'h00;
    assign busy        = (state != IDLE);

    assign done_set = ((state == IDLE) && start && (len == 16'd0)) ||
                      (wr_fire && (len_next == 16'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            src       <= 16'h0000;
            dst       <= 16'h0000;
            len       <= 16'h0000;
            inc_src   <= 1'b0;
            inc_dst   <= 1'b0;
            buffer    <= 8'h00;
            done_flag <= 1'b0;
            dout      <= 8'h00;
        end else begin
            // Set has priority over clear so a completion is never lost.
            done_flag <= done_set || (done_flag && !done_flag_clr);

            if (r_en) begin
                case (offset)
                    8'd0:    dout <= src[7:0];
                    8'd1:    dout <= src[15:8];
                    8'd2:    dout <= dst[7:0];
                    8'd3:    dout <= dst[15:8];
                    8'd4:    dout <= len[7:0];
                    8'd5:    dout <= len[15:8];
                    8'd6:    dout <= {busy, done_flag, 3'b000, inc_dst, inc_src, 1'b0};
                    default: dout <= 8'h00;
                endcase
            end else begin
                dout <= 8'h00;
            end

            if (w_en && (state == IDLE)) begin
                case (offset)
                    8'd0:    src[7:0]  <= din;
                    8'd1:    src[15:8] <= din;
                    8'd2:    dst[7:0]  <= din;
                    8'd3:    dst[15:8] <= din;
                    8'd4:    len[7:0]  <= din;
                    8'd5:    len[15:8] <= din;
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        inc_src <= din[1];
                        inc_dst <= din[2];
                        if (len != 16'd0) state <= RD;
                    end
                end
                RD: begin
                    if (abort)        state <= IDLE;
                    else if (rd_fire) state <= CAP;
                end
                CAP: begin
                    buffer <= dma_rdata;
                    state  <= abort ? IDLE : WR;
                end
                WR: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (wr_fire) begin
                        src   <= src + {15'd0, inc_src};
                        dst   <= dst + {15'd0, inc_dst};
                        len   <= len_next;
                        state <= (len_next == 16'd0) ? IDLE : RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_controller.sv
// Randomised scoreboard bench for dma_controller with a byte-array memory
// model and a transfer-level reference model.
module tb_dma_controller;

    localparam logic [7:0] BASE = 8'h90;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic [7:0]  address;
    logic        w_en;
    logic        r_en;
    logic [7:0]  dout;
    logic        cpu_bus_active = 1'b0;
    logic [15:0] dma_address;
    logic [7:0]  dma_wdata;
    logic        dma_w_en;
    logic        dma_r_en;
    logic [7:0]  dma_rdata;
    logic        busy;
    logic        done_flag;
    logic        done_flag_clr;

    // 0: bus idle, 1: CPU every second cycle, 2: random CPU traffic
    logic [1:0]  contend = 2'd0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        load_en;
    logic [15:0] load_addr;
    logic [7:0]  load_data;
    logic [7:0]  rdata_q;

    logic [23:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int strobe_cnt = 0;
    int wr_cnt = 0;

    always #5 clk = ~clk;

    dma_controller #(.DMA_ADDRESS(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .address(address), .w_en(w_en),
        .r_en(r_en), .dout(dout), .cpu_bus_active(cpu_bus_active),
        .dma_address(dma_address), .dma_wdata(dma_wdata), .dma_w_en(dma_w_en),
        .dma_r_en(dma_r_en), .dma_rdata(dma_rdata), .busy(busy),
        .done_flag(done_flag), .done_flag_clr(done_flag_clr)
    );

    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (dma_w_en) mem[dma_address] <= dma_wdata;
        if (dma_r_en) rdata_q <= mem[dma_address];
    end
    assign dma_rdata = rdata_q;

    always @(posedge clk) begin
        #1;
        case (contend)
            2'd1:    cpu_bus_active = ~cpu_bus_active;
            2'd2:    cpu_bus_active = 1'($urandom_range(0, 1));
            default: cpu_bus_active = 1'b0;
        endcase
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: every master write must match the next expected {address, data}.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dma_r_en || dma_w_en) begin
                strobe_cnt++;
                check("strobe_exclusive", {31'd0, cpu_bus_active | (dma_r_en & dma_w_en)}, 32'd0);
            end
            if (dma_w_en) begin
                wr_cnt++;
                check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check("write_data", {8'd0, dma_address, dma_wdata}, {8'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [2:0] off, input logic [7:0] d);
        address = BASE + {5'd0, off};
        din = d;
        w_en = 1'b1;
        tick();
        w_en = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] off, output logic [7:0] d);
        address = BASE + {5'd0, off};
        r_en = 1'b1;
        tick();
        d = dout;
        r_en = 1'b0;
    endtask

    task automatic read16(input logic [2:0] off, output logic [15:0] v);
        logic [7:0] lo, hi;
        reg_read(off, lo);
        reg_read(off + 3'd1, hi);
        v = {hi, lo};
    endtask

    task automatic load(input logic [15:0] a, input logic [7:0] d);
        load_en = 1'b1;
        load_addr = a;
        load_data = d;
        ref_mem[a] = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic program_regs(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
        reg_write(3'd0, s[7:0]);
        reg_write(3'd1, s[15:8]);
        reg_write(3'd2, d[7:0]);
        reg_write(3'd3, d[15:8]);
        reg_write(3'd4, n[7:0]);
        reg_write(3'd5, n[15:8]);
    endtask

    // Reference model: byte-by-byte copy over the tb's own image of memory.
    task automatic start_copy(input logic [15:0] s, input logic [15:0] d,
                              input logic [15:0] n, input logic [7:0] ctrl);
        logic [15:0] a_s, a_d;
        program_regs(s, d, n);
        for (int i = 0; i < int'(n); i++) begin
            a_s = s + (ctrl[1] ? 16'(i) : 16'd0);
            a_d = d + (ctrl[2] ? 16'(i) : 16'd0);
            ref_mem[a_d] = ref_mem[a_s];
            exp_q.push_back({a_d, ref_mem[a_s]});
        end
        reg_write(3'd6, ctrl);
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        while (busy && cycles < budget) begin
            tick();
            cycles++;
        end
        check("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic clear_done();
        done_flag_clr = 1'b1;
        tick();
        done_flag_clr = 1'b0;
    endtask

    task automatic check_regs_zero(input string tag);
        logic [7:0] v;
        for (int i = 0; i < 7; i++) begin
            reg_read(3'(i), v);
            check(tag, {24'd0, v}, 32'd0);
        end
    endtask

    initial begin
        int cyc, s0, w0, n;
        logic [15:0] v16, s, d;
        logic [7:0] v8, ctrl;

        rst_n = 1'b0; din = 8'h00; address = 8'h00; w_en = 1'b0; r_en = 1'b0;
        done_flag_clr = 1'b0; load_en = 1'b0; load_addr = 16'h0; load_data = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", {28'd0, busy, done_flag, dma_w_en, dma_r_en}, 32'd0);
        check("reset_bus", {dma_address, dma_wdata, dout}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_regs_zero("reset_regs");

        // Basic copy
        load(16'h0010, 8'hA1); load(16'h0011, 8'hB2); load(16'h0012, 8'hC3); load(16'h0013, 8'hD4);
        start_copy(16'h0010, 16'h2000, 16'd4, 8'h07);
        wait_idle(100, cyc);
        check("basic_busy_cycles", cyc, 32'd12);
        check("basic_done", {31'd0, done_flag}, 32'd1);
        read16(3'd0, v16); check("basic_src", {16'd0, v16}, 32'h0014);
        read16(3'd2, v16); check("basic_dst", {16'd0, v16}, 32'h2004);
        read16(3'd4, v16); check("basic_len", {16'd0, v16}, 32'h0000);
        check("basic_mem", {mem[16'h2000], mem[16'h2001], mem[16'h2002], mem[16'h2003]}, 32'hA1B2C3D4);
        check("basic_queue_empty", exp_q.size(), 32'd0);
        clear_done();
        reg_read(3'd6, v8); check("ctrl_readback", {24'd0, v8}, 32'h06);

        // CPU contention every second cycle
        load(16'h0020, 8'h11); load(16'h0021, 8'h22); load(16'h0022, 8'h33); load(16'h0023, 8'h44);
        contend = 2'd1;
        start_copy(16'h0020, 16'h2100, 16'd4, 8'h07);
        wait_idle(200, cyc);
        contend = 2'd0;
        check("contend_delayed", {31'd0, cyc > 12 && cyc <= 24}, 32'd1);
        check("contend_mem", {mem[16'h2100], mem[16'h2101], mem[16'h2102], mem[16'h2103]}, 32'h11223344);
        clear_done();

        // Fill mode
        load(16'h0100, 8'h55);
        start_copy(16'h0100, 16'h0200, 16'd3, 8'h05);
        wait_idle(100, cyc);
        read16(3'd0, v16); check("fill_src", {16'd0, v16}, 32'h0100);
        read16(3'd2, v16); check("fill_dst", {16'd0, v16}, 32'h0203);
        check("fill_mem", {8'd0, mem[16'h0200], mem[16'h0201], mem[16'h0202]}, 32'h00555555);
        clear_done();

        // Zero-length start
        s0 = strobe_cnt;
        program_regs(16'h0300, 16'h0400, 16'd0);
        reg_write(3'd6, 8'h07);
        check("len0_done", {30'd0, busy, done_flag}, 32'd1);
        tick(); tick();
        check("len0_no_strobes", strobe_cnt - s0, 32'd0);
        clear_done();

        // Destination wrap
        load(16'h0500, 8'h9A); load(16'h0501, 8'hBC);
        start_copy(16'h0500, 16'hFFFF, 16'd2, 8'h07);
        wait_idle(100, cyc);
        read16(3'd2, v16); check("wrap_dst", {16'd0, v16}, 32'h0001);
        check("wrap_mem", {16'd0, mem[16'hFFFF], mem[16'h0000]}, 32'h9ABC);
        clear_done();

        // Abort after first byte
        for (int i = 0; i < 5; i++) load(16'h0600 + 16'(i), 8'(8'h60 + i));
        w0 = wr_cnt;
        start_copy(16'h0600, 16'h6000, 16'd5, 8'h07);
        n = 0;
        while (wr_cnt == w0 && n < 50) begin tick(); n++; end
        check("abort_first_write", {31'd0, wr_cnt != w0}, 32'd1);
        reg_write(3'd6, 8'h08);
        check("abort_flags", {30'd0, busy, done_flag}, 32'd0);
        read16(3'd4, v16); check("abort_len", {16'd0, v16}, 32'd4);
        check("abort_pending", exp_q.size(), 32'd4);
        exp_q.delete();
        w0 = wr_cnt;
        repeat (5) tick();
        check("abort_no_more_writes", wr_cnt - w0, 32'd0);

        // Completion coinciding with clear
        load(16'h0700, 8'h77);
        start_copy(16'h0700, 16'h7100, 16'd1, 8'h07);
        tick(); tick();
        done_flag_clr = 1'b1;
        tick();
        check("set_beats_clr", {30'd0, busy, done_flag}, 32'd1);
        tick();
        check("clr_next_cycle", {31'd0, done_flag}, 32'd0);
        done_flag_clr = 1'b0;

        // Randomised transfers under random CPU traffic
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 6);
            s = 16'h3000 + 16'(t * 16);
            d = 16'h5000 + 16'(t * 16);
            ctrl = {5'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
            for (int i = 0; i < n; i++) load(s + 16'(i), 8'($urandom));
            contend = 2'($urandom_range(0, 2));
            start_copy(s, d, 16'(n), ctrl);
            wait_idle(300, cyc);
            contend = 2'd0;
            check("rand_done", {31'd0, done_flag}, 32'd1);
            read16(3'd0, v16); check("rand_src", {16'd0, v16}, {16'd0, s + (ctrl[1] ? 16'(n) : 16'd0)});
            read16(3'd2, v16); check("rand_dst", {16'd0, v16}, {16'd0, d + (ctrl[2] ? 16'(n) : 16'd0)});
            read16(3'd4, v16); check("rand_len", {16'd0, v16}, 32'd0);
            check("rand_queue_empty", exp_q.size(), 32'd0);
            clear_done();
        end

        // Asynchronous reset during a write cycle
        for (int i = 0; i < 4; i++) load(16'h0800 + 16'(i), 8'(8'h80 + i));
        start_copy(16'h0800, 16'h7800, 16'd4, 8'h07);
        n = 0;
        while (!dma_w_en && n < 50) begin tick(); n++; end
        check("reset_in_wr", {31'd0, dma_w_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_flags", {28'd0, busy, done_flag, dma_w_en, dma_r_en}, 32'd0);
        check("midreset_bus", {dma_address, dma_wdata, dout}, 32'd0);
        exp_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_regs_zero("midreset_regs");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/dma_controller.md
Name: dma_controller

Overview:
- Memory-mapped single-channel DMA engine in I/O space; copies a block of bytes between any two 16-bit data-space addresses (d_ram to GPU VRAM, RAM to RAM, I/O to RAM).
- CPU programs it through the shared io register bus, like the other peripherals.
- Its master port is muxed onto the memory bus at integration. The CPU always has priority; DMA cycle-steals idle bus cycles.
- Raises a done flag using the same set/clear handshake as the counter_timer flags.

Parameters:
- DMA_ADDRESS, 8'h90, low byte of register base in the 0x1000-0x10FF io window; 7 registers at base+0..base+6.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- din  input  8  register write data (CPU)
- address  input  8  low io address byte
- w_en  input  1  io write strobe (decoded io_w_en)
- r_en  input  1  io read strobe (decoded io_r_en)
- dout  output  8  register read data; 0 when not addressed (OR-bus)
- cpu_bus_active  input  1  CPU drives a memory access this cycle (cpu w_en | r_en)
- dma_address  output  16  master address
- dma_wdata  output  8  master write data
- dma_w_en  output  1  master write strobe
- dma_r_en  output  1  master read strobe
- dma_rdata  input  8  memory read data, valid 1 cycle after dma_r_en
- busy  output  1  transfer in progress (bus mux select qualifier)
- done_flag  output  1  transfer-complete flag
- done_flag_clr  input  1  clears done_flag

Behaviour:
- Registers:
  - +0 SRC_L, +1 SRC_H, +2 DST_L, +3 DST_H, +4 LEN_L, +5 LEN_H.
  - +6 CTRL. Write: bit0 start, bit1 inc_src, bit2 inc_dst, bit3 abort. Read: {busy, done_flag, 3'b0, inc_dst, inc_src, 1'b0}.
- Reads:
  - dout is registered: valid the cycle after r_en with a matching address, 0 otherwise.
  - SRC/DST/LEN always read back live working values.
- Reset: all registers 0, state IDLE. Outputs busy, done_flag, dma_w_en, dma_r_en, dma_address, dma_wdata, dout are all 0.
- Writes while busy: writes to +0..+5 are ignored; only the CTRL abort bit is honoured. A start bit while busy is ignored.
- FSM states are IDLE, RD, CAP, WR.
  - IDLE: on CTRL write with start=1, latch inc_src/inc_dst. If LEN==0, set done_flag next cycle, stay IDLE, and make no bus cycles. Otherwise go to RD with busy=1.
  - RD: if cpu_bus_active=0, drive dma_r_en=1 and dma_address=SRC, then go to CAP. If cpu_bus_active=1, drive nothing and hold.
  - CAP: capture dma_rdata into the data buffer unconditionally (data is valid exactly 1 cycle after dma_r_en, independent of CPU activity), then go to WR.
  - WR: if cpu_bus_active=0, drive dma_w_en=1, dma_address=DST, dma_wdata=buffer. Same cycle: SRC+=inc_src, DST+=inc_dst, LEN-=1. If the new LEN==0, go to IDLE, clear busy, and set done_flag. Else go to RD. If cpu_bus_active=1, hold.
- dma_r_en and dma_w_en are never asserted in a cycle with cpu_bus_active=1, and never both at once.
- Throughput: 3 cycles/byte with an idle bus; each stalled cycle adds 1.
- Arithmetic: SRC/DST increment mod 2^16 (0xFFFF wraps to 0x0000); LEN is 16-bit, max 65535 bytes.
- Abort (CTRL bit3=1, any state):
  - Next state IDLE, busy=0, done_flag unchanged; SRC/DST/LEN keep their current values.
  - Abort and start in the same write: abort wins.
  - Abort in CAP/WR discards the buffered byte; no write is issued.
- done_flag: set on completion and held until done_flag_clr=1. Set and clr in the same cycle: set wins. A new start does not clear the flag.
- Async reset mid-transfer: immediate return to the reset state; the partial copy is not resumed.

Test Plan:
- Basic copy: SRC=0x0010, DST=0x2000, LEN=4, CTRL=0x07, bus idle, memory 0x10..0x13 = A1,B2,C3,D4.
  - Expect 2000..2003 = A1,B2,C3,D4.
  - Expect busy for 12 cycles, then done_flag=1.
  - Expect final SRC=0x0014, DST=0x2004, LEN=0.
- CPU contention: same copy with cpu_bus_active=1 in every 2nd cycle.
  - Expect no cycle with both cpu_bus_active and a dma strobe high.
  - Expect data correct and completion delayed by the number of stalled cycles.
- Fill mode: CTRL=0x05 (inc_src=0), SRC=0x0100 holding 0x55, DST=0x0200, LEN=3 -> 0x0200..0x0202 = 0x55, and SRC stays 0x0100.
- Boundaries:
  - LEN=0 start -> done_flag=1 next cycle with no dma strobes.
  - DST=0xFFFF, LEN=2, inc_dst -> writes to 0xFFFF then 0x0000.
- Abort and flag handshake:
  - Write CTRL=0x08 after 1 byte of a LEN=5 transfer -> busy=0 within 1 cycle, LEN reads 4, done_flag stays 0.
  - Completion coinciding with done_flag_clr -> flag stays 1; clr on the next cycle -> 0.
- Reset mid-transfer: drop rst_n during WR -> all outputs 0 immediately and registers read 0 after release.
